// File: rtl/fft4_out_serializer.sv
// rtl/fft4_out_serializer.sv - ping-pong buffered serializer for 4-bin complex FFT frames
module fft4_out_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH+1:0] in0_real,
   input  logic signed [DATA_WIDTH+1:0] in0_imag,
   input  logic signed [DATA_WIDTH+1:0] in1_real,
   input  logic signed [DATA_WIDTH+1:0] in1_imag,
   input  logic signed [DATA_WIDTH+1:0] in2_real,
   input  logic signed [DATA_WIDTH+1:0] in2_imag,
   input  logic signed [DATA_WIDTH+1:0] in3_real,
   input  logic signed [DATA_WIDTH+1:0] in3_imag,
   output logic signed [DATA_WIDTH+1:0] out_real,
   output logic signed [DATA_WIDTH+1:0] out_imag,
   output logic [1:0]                   out_idx,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         overflow,
   output logic [1:0]                   frames
);

   localparam int SW = DATA_WIDTH + 2;

   // Two frame slots of four complex bins; contents are never reset.
   logic signed [SW-1:0] buf_real_q [2][4];
   logic signed [SW-1:0] buf_real_d [2][4];
   logic signed [SW-1:0] buf_imag_q [2][4];
   logic signed [SW-1:0] buf_imag_d [2][4];

   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;
   logic [1:0]           idx_q, idx_d;
   logic                 overflow_q, overflow_d;

   logic signed [SW-1:0] in_real [4];
   logic signed [SW-1:0] in_imag [4];
   logic                 xfer;
   logic                 last_xfer;
   logic                 accept;

   // Gather the flat input ports into indexable bin arrays.
   always_comb begin
      in_real[0] = in0_real;
      in_real[1] = in1_real;
      in_real[2] = in2_real;
      in_real[3] = in3_real;
      in_imag[0] = in0_imag;
      in_imag[1] = in1_imag;
      in_imag[2] = in2_imag;
      in_imag[3] = in3_imag;
   end

   // Handshake decode: a full buffer can still take a frame when its oldest frame leaves this cycle.
   always_comb begin
      xfer      = (count_q != 2'd0) && out_ready;
      last_xfer = xfer && (idx_q == 2'd3);
      accept    = in_valid && ((count_q < 2'd2) || last_xfer);
   end

   // Next-state for pointers, occupancy, bin index, sticky overflow and buffer slots.
   always_comb begin
      buf_real_d = buf_real_q;
      buf_imag_d = buf_imag_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      idx_d      = idx_q;
      overflow_d = overflow_q;
      count_d    = count_q + {1'b0, accept} - {1'b0, last_xfer};

      if (accept) begin
         for (int b = 0; b < 4; b++) begin
            buf_real_d[wr_ptr_q][b] = in_real[b];
            buf_imag_d[wr_ptr_q][b] = in_imag[b];
         end
         wr_ptr_d = ~wr_ptr_q;
      end else if (in_valid) begin
         overflow_d = 1'b1;
      end

      if (xfer) begin
         idx_d = idx_q + 2'd1;
      end
      if (last_xfer) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   // Control state, cleared asynchronously so a reset mid-frame discards everything buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         idx_q      <= 2'd0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
      end
   end

   // Frame storage; validity is tracked by count_q so the data itself needs no reset.
   always_ff @(posedge clk) begin
      buf_real_q <= buf_real_d;
      buf_imag_q <= buf_imag_d;
   end

   // Serial output: current bin of the read slot, forced to zero while the buffer is empty.
   always_comb begin
      out_valid = (count_q != 2'd0);
      out_idx   = idx_q;
      out_last  = out_valid && (idx_q == 2'd3);
      overflow  = overflow_q;
      frames    = count_q;
      if (out_valid) begin
         out_real = buf_real_q[rd_ptr_q][idx_q];
         out_imag = buf_imag_q[rd_ptr_q][idx_q];
      end else begin
         out_real = '0;
         out_imag = '0;
      end
   end

endmodule

// File: tb/tb_fft4_out_serializer.sv
// tb/tb_fft4_out_serializer.sv - self-checking bench for fft4_out_serializer
module tb_fft4_out_serializer;

   localparam int DW = 8;
   localparam int SW = DW + 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [SW-1:0] in0_real = '0, in0_imag = '0, in1_real = '0, in1_imag = '0;
   logic signed [SW-1:0] in2_real = '0, in2_imag = '0, in3_real = '0, in3_imag = '0;
   logic signed [SW-1:0] out_real, out_imag;
   logic [1:0]           out_idx;
   logic                 out_last, out_valid;
   logic                 out_ready = 1'b0;
   logic                 overflow;
   logic [1:0]           frames;

   fft4_out_serializer #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in0_real(in0_real), .in0_imag(in0_imag), .in1_real(in1_real), .in1_imag(in1_imag),
      .in2_real(in2_real), .in2_imag(in2_imag), .in3_real(in3_real), .in3_imag(in3_imag),
      .out_real(out_real), .out_imag(out_imag), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .frames(frames)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [SW-1:0] re [4];
      logic signed [SW-1:0] im [4];
   } frame_t;

   typedef struct {
      bit         iv;
      bit         rdy;
      bit         e_valid;
      logic [1:0] e_idx;
      int         e_re;
      int         e_im;
      bit         e_last;
      logic [1:0] e_frames;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: FIFO of whole frames plus the bin currently presented.
   frame_t mq[$];
   int     m_bin = 0;
   bit     m_ovf = 1'b0;

   function automatic frame_t rand_frame();
      frame_t f;
      for (int b = 0; b < 4; b++) begin
         f.re[b] = SW'($urandom);
         f.im[b] = SW'($urandom);
      end
      return f;
   endfunction

   function automatic frame_t make_frame(input int r0, i0, r1, i1, r2, i2, r3, i3);
      frame_t f;
      f.re[0] = SW'(r0); f.im[0] = SW'(i0);
      f.re[1] = SW'(r1); f.im[1] = SW'(i1);
      f.re[2] = SW'(r2); f.im[2] = SW'(i2);
      f.re[3] = SW'(r3); f.im[3] = SW'(i3);
      return f;
   endfunction

   task automatic drive(input bit iv, input frame_t f, input bit rdy);
      in_valid = iv;
      out_ready = rdy;
      in0_real = f.re[0]; in0_imag = f.im[0];
      in1_real = f.re[1]; in1_imag = f.im[1];
      in2_real = f.re[2]; in2_imag = f.im[2];
      in3_real = f.re[3]; in3_imag = f.im[3];
   endtask

   task automatic model_reset();
      mq.delete();
      m_bin = 0;
      m_ovf = 1'b0;
   endtask

   task automatic model_step(input bit iv, input frame_t f, input bit rdy);
      if (mq.size() > 0 && rdy) begin
         if (m_bin == 3) begin
            void'(mq.pop_front());
            m_bin = 0;
         end else begin
            m_bin++;
         end
      end
      if (iv) begin
         if (mq.size() < 2) mq.push_back(f);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic check_model(input string name);
      bit         ev;
      logic [1:0] ei;
      int         er, ei_im;
      bit         el;
      ev    = (mq.size() > 0);
      ei    = ev ? 2'(m_bin) : 2'd0;
      er    = ev ? int'(mq[0].re[m_bin]) : 0;
      ei_im = ev ? int'(mq[0].im[m_bin]) : 0;
      el    = ev && (m_bin == 3);
      n_vec++;
      if (out_valid !== ev || out_idx !== ei || int'(out_real) != er || int'(out_imag) != ei_im ||
          out_last !== el || frames !== 2'(mq.size()) || overflow !== m_ovf) begin
         n_bad++;
         $display("FAIL %s: got v=%0b idx=%0d re=%0d im=%0d last=%0b fr=%0d ovf=%0b, want v=%0b idx=%0d re=%0d im=%0d last=%0b fr=%0d ovf=%0b",
                  name, out_valid, out_idx, out_real, out_imag, out_last, frames, overflow,
                  ev, ei, er, ei_im, el, mq.size(), m_ovf);
      end
   endtask

   // One clock: drive at the falling edge, check state, predict the rising edge, advance.
   task automatic cycle(input string name, input bit iv, input frame_t f, input bit rdy);
      drive(iv, f, rdy);
      check_model(name);
      model_step(iv, f, rdy);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b want %0b", name, act, exp);
      end
   endtask

   task automatic do_reset();
      frame_t z;
      z = make_frame(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1'b0, z, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   vec_t   tbl [6];
   frame_t f28, f1, f2, f3, f4, idle;

   initial begin
      idle = make_frame(0, 0, 0, 0, 0, 0, 0, 0);
      f28  = make_frame(10, 0, -3, 4, 511, -512, 0, -1);

      // Reset-state outputs
      do_reset();
      check_model("reset_state");

      // Single frame with the exact bins, including the most negative value
      tbl[0] = '{1'b1, 1'b1, 1'b1, 2'd0,  10,    0, 1'b0, 2'd1};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 2'd1,  -3,    4, 1'b0, 2'd1};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 2'd2, 511, -512, 1'b0, 2'd1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 2'd3,   0,   -1, 1'b1, 2'd1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd0,   0,    0, 1'b0, 2'd0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd0,   0,    0, 1'b0, 2'd0};
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].iv, f28, tbl[i].rdy);
         @(posedge clk);
         @(negedge clk);
         n_vec++;
         if (out_valid !== tbl[i].e_valid || out_idx !== tbl[i].e_idx || int'(out_real) != tbl[i].e_re ||
             int'(out_imag) != tbl[i].e_im || out_last !== tbl[i].e_last || frames !== tbl[i].e_frames) begin
            n_bad++;
            $display("FAIL table[%0d]: got v=%0b idx=%0d re=%0d im=%0d last=%0b fr=%0d, want v=%0b idx=%0d re=%0d im=%0d last=%0b fr=%0d",
                     i, out_valid, out_idx, out_real, out_imag, out_last, frames, tbl[i].e_valid,
                     tbl[i].e_idx, tbl[i].e_re, tbl[i].e_im, tbl[i].e_last, tbl[i].e_frames);
         end
      end

      // Backpressure pattern 1,0,0,1,0,1,1
      do_reset();
      f1 = rand_frame();
      cycle("bp_load", 1'b1, f1, 1'b0);
      begin
         bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
         for (int i = 0; i < 7; i++) cycle("backpressure", 1'b0, idle, pat[i]);
      end
      cycle("bp_drain", 1'b0, idle, 1'b1);

      // Three consecutive frames into a stalled output: third is dropped
      do_reset();
      f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
      cycle("ovf_f1", 1'b1, f1, 1'b0);
      cycle("ovf_f2", 1'b1, f2, 1'b0);
      cycle("ovf_f3", 1'b1, f3, 1'b0);
      check_bit("ovf_flag", overflow, 1'b1);
      check_bit("ovf_frames2", frames[1], 1'b1);
      for (int i = 0; i < 10; i++) cycle("ovf_drain", 1'b0, idle, 1'b1);
      check_bit("ovf_sticky", overflow, 1'b1);

      // Full buffer, F3 offered on the last-bin transfer of F1: accepted
      do_reset();
      f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
      cycle("sim_f1", 1'b1, f1, 1'b0);
      cycle("sim_f2", 1'b1, f2, 1'b0);
      for (int i = 0; i < 3; i++) cycle("sim_bins", 1'b0, idle, 1'b1);
      cycle("sim_f3", 1'b1, f3, 1'b1);
      check_bit("sim_frames2", frames[1], 1'b1);
      for (int i = 0; i < 10; i++) cycle("sim_drain", 1'b0, idle, 1'b1);
      check_bit("sim_no_ovf", overflow, 1'b0);

      // Frame every fourth cycle with a free-running sink: continuous output
      do_reset();
      for (int i = 0; i < 24; i++) begin
         cycle("stream", (i % 4) == 0, rand_frame(), 1'b1);
         if (i > 0) check_bit("stream_valid", out_valid, 1'b1);
      end
      for (int i = 0; i < 4; i++) cycle("stream_tail", 1'b0, idle, 1'b1);

      // Reset mid-frame with two frames buffered
      do_reset();
      f1 = rand_frame(); f2 = rand_frame(); f4 = rand_frame();
      cycle("rst_f1", 1'b1, f1, 1'b0);
      cycle("rst_f2", 1'b1, f2, 1'b1);
      cycle("rst_adv", 1'b0, idle, 1'b1);
      check_model("rst_pre");
      rst_n = 1'b0;
      #1;
      check_bit("rst_valid0", out_valid, 1'b0);
      check_bit("rst_ovf0", overflow, 1'b0);
      n_vec++;
      if (out_idx !== 2'd0 || out_real !== '0 || out_imag !== '0 || frames !== 2'd0 || out_last !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_async: got idx=%0d re=%0d im=%0d fr=%0d last=%0b, want all 0",
                  out_idx, out_real, out_imag, frames, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle("rst_new", 1'b1, f4, 1'b1);
      for (int i = 0; i < 5; i++) cycle("rst_new_out", 1'b0, idle, 1'b1);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle("random", ($urandom % 3) == 0, rand_frame(), ($urandom % 4) != 0);
      end
      for (int i = 0; i < 12; i++) cycle("random_drain", 1'b0, idle, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fft4_out_serializer.md
FFT4_OUT_SERIALIZER -- requirements
Module: fft4_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: the width of the 4-point FFT input samples; result samples are DATA_WIDTH+2 bits, signed two's complement.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a 4-bin FFT result frame is present this cycle; it is driven by the upstream 4-point FFT output-valid.
REQ-005 The block SHALL have ports in0_real, in0_imag, in1_real, in1_imag, in2_real, in2_imag, in3_real, in3_imag, each input, DATA_WIDTH+2 bits signed: bins 0..3 of the frame.
REQ-006 The block SHALL have ports out_real and out_imag, each output, DATA_WIDTH+2 bits signed: the current serial bin.
REQ-007 The block SHALL have port out_idx, output, 2 bits: the bin number of the current output.
REQ-008 The block SHALL have port out_last, output, 1 bit: high when out_idx==3 and out_valid is high.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the serial output is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a frame is dropped.
REQ-012 The block SHALL have port frames, output, 2 bits: the number of buffered frames (0..2).

Function
REQ-013 The block SHALL hold a 2-frame ping-pong buffer of registers (4 complex bins per frame), with 1-bit write pointer wr_ptr, 1-bit read pointer rd_ptr, and a 2-bit occupancy count.
REQ-014 A frame SHALL be accepted at the rising edge where in_valid=1 and either count<2, or count==2 and a last-bin transfer occurs in the same cycle.
- On acceptance, all 8 inputs are written to slot wr_ptr and wr_ptr toggles.
REQ-015 The block SHALL drop a frame offered when count==2 with no same-cycle last-bin transfer.
- The buffer and pointers are unchanged.
- overflow is set to 1 and stays set until reset.
REQ-016 The block SHALL drive out_valid=1 exactly when count>0.
REQ-017 The block SHALL drive out_real and out_imag from bin out_idx of slot rd_ptr (a registered buffer feeding a mux, with no added latency).
REQ-018 The block SHALL give a latency of 1 cycle: a frame accepted at edge N with count==0 beforehand shows bin 0 with out_valid=1 after edge N.
REQ-019 The block SHALL output bins in the fixed order 0,1,2,3.
- out_idx increments on each transfer.
- On the transfer with out_idx==3, out_idx wraps to 0, rd_ptr toggles and count decrements.
REQ-020 When out_ready=0, the block SHALL hold out_real, out_imag, out_idx and out_valid stable (no skipped or duplicated bins).
REQ-021 On a simultaneous accept and last-bin transfer, count SHALL stay unchanged; both pointers toggle.
REQ-022 When count==0, the block SHALL drive out_real=0, out_imag=0 and out_idx=0.
REQ-023 in_valid high on consecutive cycles SHALL be treated as consecutive distinct frames.
REQ-024 The block SHALL perform no arithmetic on the data: it passes values bit-exact, including the most negative value -2^(DATA_WIDTH+1).

Reset
REQ-025 While rst_n=0, asynchronously, the block SHALL drive out_valid=0, out_last=0, out_idx=0, out_real=0, out_imag=0, overflow=0 and frames=0, and clear wr_ptr, rd_ptr and count.
- Buffer contents need not be cleared.
REQ-026 Reset asserted mid-frame SHALL discard all buffered frames.
- After release, the next accepted frame starts at bin 0.
REQ-027 The block SHALL accept in_valid on the first rising edge after rst_n deasserts.

Verification
REQ-028 Single frame, out_ready=1, DATA_WIDTH=8, bins (10,0),(-3,4),(511,-512),(0,-1) -> out_valid on 4 consecutive cycles starting 1 cycle after capture, idx 0..3, exact values, out_last only on idx 3, then out_valid=0.
REQ-029 Backpressure: out_ready toggles 1,0,0,1,0,1,1 -> each bin is presented until accepted, 4 transfers total, order 0..3 preserved.
REQ-030 out_ready=0, three frames F1,F2,F3 on consecutive cycles -> frames=2, overflow=1, F3 dropped; after out_ready=1, 8 transfers of F1 then F2.
REQ-031 count==2 with the last bin of F1 being transferred while F3 is offered in the same cycle -> F3 accepted, overflow stays 0, output sequence F1,F2,F3.
REQ-032 Continuous in_valid every 4th cycle with out_ready=1 -> out_valid stays 1 continuously, frames never exceeds 1, no overflow.
REQ-033 rst_n pulsed low while frames=2 and idx=2 -> all outputs 0 immediately; after release, a new frame is output starting at idx 0 with its own data.
